sram_ctrl: RTL and testbench
============================

# sram_ctrl

Parametrised clocked controller that lets an on-chip bus master read and write words of DW bits in an external asynchronous x8 SRAM. Each word access becomes a sequence of byte cycles with programmable wait states, glitch-free registered strobes and byte-enable skipping. It replaces direct combinational wiring to the SRAM pins. Multi-byte words are big-endian, matching xr16 memory order.

## Interface
Parameters:
- DW, 16: word width; multiple of 8, range 8..32. NB = DW/8 byte lanes; LB = log2(NB).
- AW, 15: external byte address width.
- WS, 1: extra strobe cycles per byte; range 0..15. The strobe lasts WS+1 cycles.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  AW  byte address; low LB bits ignored (word aligned).
- be  in  NB  write byte enables; be[i] qualifies lane i. Ignored on reads.
- wdata  in  DW  write data; lane i = wdata[8i+7:8i].
- rdata  out  DW  read data; valid with ack; holds until the next read completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance through the ack cycle.
- ram_ce_n, ram_we_n, ram_oe_n  out  1 each  active-low SRAM controls; registered.
- ram_addr  out  AW  SRAM byte address.
- ram_dq_o  out  8  write data to the pad.
- ram_dq_oe  out  1  pad output enable.
- ram_dq_i  in  8  read data from the pad.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- Big-endian mapping: byte offset k (0..NB-1) sits at ram_addr = {addr[AW-1:LB], k} and maps to lane NB-1-k.
- IDLE, req=1: latch we, addr, be and wdata, and build a byte mask (all ones for reads, be for writes).
  - If the mask is nonzero, go to SETUP for the lowest enabled k.
  - If the mask is zero, go to DONE.
- SETUP (1 cycle):
  - ram_addr = byte address, ram_ce_n = 0, ram_we_n = 1, ram_oe_n = 1.
  - Write: ram_dq_oe = 1 and ram_dq_o = lane data.
- STROBE (WS+1 cycles, wait counter): as SETUP, plus ram_we_n = 0 (write) or ram_oe_n = 0 (read).
  - Read: on the last STROBE cycle, capture ram_dq_i into rdata lane NB-1-k.
- HOLD (1 cycle): strobes high; ram_ce_n, ram_addr, ram_dq_o and ram_dq_oe unchanged. Then:
  - go to SETUP for the next enabled k in ascending order, or
  - go to DONE if no enabled k remains.
- DONE (1 cycle): ack = 1, ram_ce_n = 1, ram_dq_oe = 0. Then go to IDLE.
- Write-disabled lanes consume no cycles, and their SRAM bytes are untouched.
- ram_addr and ram_dq_o never change while a strobe is low.
- ram_dq_oe is never high on a read.
- req in any state other than IDLE is ignored; it is not queued.
- Reset values, applied asynchronously:
  - state IDLE; ram_ce_n, ram_we_n, ram_oe_n = 1.
  - ram_dq_oe = 0, ram_addr = 0, ram_dq_o = 0.
  - rdata = 0, ack = 0, busy = 0.
- Reset asserted mid-transfer: strobes deassert immediately, the transfer is abandoned, and no ack is issued.

## Timing
- Acceptance edge = E0. Cycle n = the cycle after edge En-1.
- Each enabled byte takes WS+3 cycles. With m enabled bytes, ack is high in cycle m·(WS+3)+1.
- Mask zero: ack in cycle 1.
- busy = 1 from cycle 1 through the ack cycle, inclusive.
- DW=16, WS=1 read: SETUP c1, STROBE c2–c3, HOLD c4 (byte 0); byte 1 in c5–c8; ack in c9.
- A new req is accepted at the earliest on the edge ending the cycle after ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst mid-idle. All outputs take their reset values with no clock edge; release, idle 5 cycles, and they stay unchanged.
- Read, DW=16, WS=1, SRAM[0x0010] = 0x12 and SRAM[0x0011] = 0x34, req with addr = 0x0011:
  - ram_addr goes 0x0010 then 0x0011;
  - ram_oe_n is low in c2–c3 and c6–c7;
  - rdata = 0x1234 with ack in c9;
  - busy is high c1–c9.
- Partial write, DW=16, WS=1, addr = 0x0020, wdata = 0xABCD, be = 01:
  - only SRAM[0x0021] = 0xCD is written, and SRAM[0x0020] is unchanged;
  - ram_we_n is low in c2–c3; ack in c5.
- Empty write, be = 00: ack in c1; ram_ce_n, ram_we_n and ram_dq_oe never assert.
- DW=32, WS=0, read of 0x11223344 at addr 0x0040: ack in c13 with rdata = 0x11223344. A req held high during busy starts no second transfer.
- Reset mid-write: assert rst during the STROBE cycle of byte 0. ram_we_n goes high immediately, there is no ack, and the next req works normally.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: word-wide bus access to an external asynchronous x8 SRAM.
// Each word is split into big-endian byte cycles (SETUP / STROBE / HOLD),
// skipping byte lanes that are not write-enabled. Every pin is driven
// straight from a flop so strobes are glitch-free.
module sram_ctrl #(
  parameter int DW = 16,
  parameter int AW = 15,
  parameter int WS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy,
  output logic          ram_ce_n,
  output logic          ram_we_n,
  output logic          ram_oe_n,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_dq_o,
  output logic          ram_dq_oe,
  input  logic [7:0]    ram_dq_i
);

  localparam int NB = DW / 8;
  // byte-offset counter width; kept at least 1 bit for the single-lane case
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [NB-1:0]   mask_q, mask_d, m_new, rem;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rbuf_q, rbuf_d;
  logic            active;

  logic            ce_n_d, we_n_d, oe_n_d, dq_oe_d, ack_d, busy_d;
  logic [AW-1:0]   ram_addr_d;
  logic [7:0]      dq_o_d;
  logic [DW-1:0]   rdata_d;

  // lowest enabled byte offset; offsets are visited in ascending order
  function automatic logic [KW-1:0] first_k(input logic [NB-1:0] m);
    first_k = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (m[i]) first_k = KW'(i);
  endfunction

  // next-state logic, then next values for every registered pin
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mask_d  = mask_q;
    wcnt_d  = wcnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    m_new   = '0;
    rem     = '0;

    case (state_q)
      IDLE: if (req) begin
        wr_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        // offset k lives in lane NB-1-k (big-endian)
        for (int i = 0; i < NB; i++)
          m_new[i] = we ? be[NB-1-i] : 1'b1;
        mask_d = m_new;
        if (|m_new) begin
          state_d = SETUP;
          k_d     = first_k(m_new);
        end else begin
          state_d = DONE;
        end
      end
      SETUP: begin
        state_d = STROBE;
        wcnt_d  = '0;
      end
      STROBE: begin
        if (wcnt_q == 4'(WS)) begin
          state_d = HOLD;
          if (!wr_q) rbuf_d[8*(NB-1-int'(k_q)) +: 8] = ram_dq_i;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      HOLD: begin
        rem      = mask_q;
        rem[k_q] = 1'b0;
        mask_d   = rem;
        if (|rem) begin
          state_d = SETUP;
          k_d     = first_k(rem);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // pins reflect the state being entered, so they are valid for the
    // whole cycle the state is held
    active     = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    ce_n_d     = !active;
    we_n_d     = !((state_d == STROBE) && wr_d);
    oe_n_d     = !((state_d == STROBE) && !wr_d);
    dq_oe_d    = active && wr_d;
    ram_addr_d = ram_addr;
    dq_o_d     = ram_dq_o;
    // address/data only move when entering SETUP, when both strobes are high
    if (state_d == SETUP) begin
      ram_addr_d = (addr_d & ~AW'(NB - 1)) | AW'(k_d);
      if (wr_d) dq_o_d = wdata_d[8*(NB-1-int'(k_d)) +: 8];
    end
    // bytes gather in rbuf so rdata only changes when a read completes
    rdata_d = rdata;
    if ((state_d == DONE) && !wr_d) rdata_d = rbuf_d;
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // state, transfer context and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      mask_q    <= '0;
      wcnt_q    <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      ram_ce_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_dq_oe <= 1'b0;
      ram_addr  <= '0;
      ram_dq_o  <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      mask_q    <= mask_d;
      wcnt_q    <= wcnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      ram_ce_n  <= ce_n_d;
      ram_we_n  <= we_n_d;
      ram_oe_n  <= oe_n_d;
      ram_dq_oe <= dq_oe_d;
      ram_addr  <= ram_addr_d;
      ram_dq_o  <= dq_o_d;
      rdata     <= rdata_d;
      ack       <= ack_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: a 16-bit/WS=1 instance and a 32-bit/WS=0
// instance, each hooked to a small behavioural x8 SRAM.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // ---------------- instance 0: DW=16, WS=1
  logic        req0 = 0, we0 = 0;
  logic [14:0] addr0 = '0;
  logic [1:0]  be0 = '0;
  logic [15:0] wdata0 = '0, rdata0;
  logic        ack0, busy0, ram_ce_n0, ram_we_n0, ram_oe_n0, ram_dq_oe0;
  logic [14:0] ram_addr0;
  logic [7:0]  ram_dq_o0, ram_dq_i0;
  logic [7:0]  mem0 [0:32767];

  sram_ctrl #(.DW(16), .AW(15), .WS(1)) u16 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .be(be0),
    .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0),
    .ram_ce_n(ram_ce_n0), .ram_we_n(ram_we_n0), .ram_oe_n(ram_oe_n0),
    .ram_addr(ram_addr0), .ram_dq_o(ram_dq_o0), .ram_dq_oe(ram_dq_oe0),
    .ram_dq_i(ram_dq_i0));

  assign ram_dq_i0 = (!ram_ce_n0 && !ram_oe_n0) ? mem0[ram_addr0] : 8'hEE;
  always @(posedge clk) if (!ram_ce_n0 && !ram_we_n0) mem0[ram_addr0] <= ram_dq_o0;

  // ---------------- instance 1: DW=32, WS=0 (reads only)
  logic        req1 = 0;
  logic [14:0] addr1 = '0;
  logic [31:0] rdata1;
  logic        ack1, busy1, ram_ce_n1, ram_we_n1, ram_oe_n1, ram_dq_oe1;
  logic [14:0] ram_addr1;
  logic [7:0]  ram_dq_o1, ram_dq_i1;
  logic [7:0]  mem1 [0:32767];

  sram_ctrl #(.DW(32), .AW(15), .WS(0)) u32 (
    .clk(clk), .rst(rst), .req(req1), .we(1'b0), .addr(addr1), .be(4'b0000),
    .wdata(32'h0), .rdata(rdata1), .ack(ack1), .busy(busy1),
    .ram_ce_n(ram_ce_n1), .ram_we_n(ram_we_n1), .ram_oe_n(ram_oe_n1),
    .ram_addr(ram_addr1), .ram_dq_o(ram_dq_o1), .ram_dq_oe(ram_dq_oe1),
    .ram_dq_i(ram_dq_i1));

  assign ram_dq_i1 = (!ram_ce_n1 && !ram_oe_n1) ? mem1[ram_addr1] : 8'hEE;

  // ---------------- scoreboard
  typedef struct {
    int          at;
    logic [31:0] rd;
    bit          chk;
  } exp_t;

  exp_t q0[$], q1[$];
  int   tests = 0, fails = 0;
  int   ack_cnt0 = 0, ack_cnt1 = 0;
  int   base0 = -1000, base1 = -1000;
  bit   rd_wr1 = 0;   // sticky: u32 ever drove write controls

  logic [14:0] tr_addr0 [64];
  logic        tr_oe0 [64], tr_we0 [64], tr_ce0 [64], tr_dqoe0 [64], tr_busy0 [64];
  logic        tr_busy1 [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: record per-cycle pin trace and pop the scoreboard on each ack
  always @(negedge clk) begin
    int c0, c1;
    exp_t e;
    c0 = ecnt - base0;
    c1 = ecnt - base1;
    if (c0 >= 0 && c0 < 64) begin
      tr_addr0[c0] = ram_addr0; tr_oe0[c0] = ram_oe_n0; tr_we0[c0] = ram_we_n0;
      tr_ce0[c0] = ram_ce_n0; tr_dqoe0[c0] = ram_dq_oe0; tr_busy0[c0] = busy0;
    end
    if (c1 >= 0 && c1 < 64) tr_busy1[c1] = busy1;
    if (!ram_we_n1 || ram_dq_oe1) rd_wr1 = 1'b1;
    if (ack0) begin
      ack_cnt0++;
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL u16_unexpected_ack: ack at edge %0d with nothing pending", ecnt);
      end else begin
        e = q0.pop_front();
        chk("u16_ack_cycle", ecnt, e.at);
        if (e.chk) chk("u16_rdata", {16'h0, rdata0}, e.rd);
      end
    end
    if (ack1) begin
      ack_cnt1++;
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL u32_unexpected_ack: ack at edge %0d with nothing pending", ecnt);
      end else begin
        e = q1.pop_front();
        chk("u32_ack_cycle", ecnt, e.at);
        if (e.chk) chk("u32_rdata", rdata1, e.rd);
      end
    end
  end

  // issue one u16 transfer, expect ack in cycle n, then wait for it
  task automatic go16(input logic w, input logic [14:0] a, input logic [1:0] b,
                      input logic [15:0] wd, input int n, input logic [31:0] erd);
    @(negedge clk); #1;
    req0 = 1'b1; we0 = w; addr0 = a; be0 = b; wdata0 = wd;
    base0 = ecnt;
    q0.push_back('{at: ecnt + n, rd: erd, chk: !w});
    @(posedge clk); #1 req0 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (q0.size() == 0) break;
      @(negedge clk); #2;
    end
    if (q0.size() != 0) begin
      tests++; fails++;
      $display("FAIL u16_timeout: no ack, %0d pending", q0.size());
      q0.delete();
    end
  endtask

  initial begin
    logic [8:0] oe_v;
    logic [9:0] busy_v;
    logic [4:0] we_v;
    logic [12:0] b1_v;
    bit         any;
    int         sav;

    for (int i = 0; i < 32768; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    mem0[15'h0010] = 8'h12; mem0[15'h0011] = 8'h34; mem0[15'h0020] = 8'h55;
    mem1[15'h0040] = 8'h11; mem1[15'h0041] = 8'h22;
    mem1[15'h0042] = 8'h33; mem1[15'h0043] = 8'h44;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- read 0x1234 from word at 0x0010 (addr low bit ignored)
    go16(1'b0, 15'h0011, 2'b00, 16'h0, 9, 32'h1234);
    @(negedge clk); #2;
    chk("rd_addr_c1", tr_addr0[1], 15'h0010);
    chk("rd_addr_c5", tr_addr0[5], 15'h0011);
    for (int c = 1; c <= 9; c++) oe_v[c-1] = tr_oe0[c];
    chk("rd_oe_n_c1_c9", oe_v, 9'b110011001);
    for (int c = 1; c <= 10; c++) busy_v[c-1] = tr_busy0[c];
    chk("rd_busy_c1_c10", busy_v, 10'b0111111111);
    any = 0;
    for (int c = 1; c <= 9; c++) any |= tr_dqoe0[c];
    chk("rd_dq_oe_never", any, 1'b0);

    // ---- partial write: only lane 0 (offset 1 -> 0x0021)
    go16(1'b1, 15'h0020, 2'b01, 16'hABCD, 5, 32'h0);
    for (int c = 1; c <= 5; c++) we_v[c-1] = tr_we0[c];
    chk("wr_we_n_c1_c5", we_v, 5'b11001);
    chk("wr_mem_0021", mem0[15'h0021], 8'hCD);
    chk("wr_mem_0020", mem0[15'h0020], 8'h55);

    // ---- empty write: no lanes enabled
    go16(1'b1, 15'h0024, 2'b00, 16'hFFFF, 1, 32'h0);
    @(negedge clk); @(negedge clk); #2;
    any = 0;
    for (int c = 1; c <= 3; c++) any |= !tr_ce0[c] | !tr_we0[c] | tr_dqoe0[c];
    chk("empty_no_strobes", any, 1'b0);

    // ---- reset while idle: outputs clear without a clock edge
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", {ram_ce_n0, ram_we_n0, ram_oe_n0, ram_dq_oe0, ack0, busy0}, 6'b111000);
    chk("rst_addr", ram_addr0, 15'h0);
    chk("rst_dq_o", ram_dq_o0, 8'h0);
    chk("rst_rdata", rdata0, 16'h0);
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("rst_idle_hold", {ram_ce_n0, ram_we_n0, ram_oe_n0, ram_dq_oe0, ack0, busy0,
                            ram_addr0, ram_dq_o0, rdata0}, {6'b111000, 15'h0, 8'h0, 16'h0});
    end

    // ---- 32-bit read, WS=0, req held high during busy
    @(negedge clk); #1;
    req1 = 1'b1; addr1 = 15'h0040; base1 = ecnt; sav = ack_cnt1;
    q1.push_back('{at: ecnt + 13, rd: 32'h11223344, chk: 1'b1});
    repeat (13) @(negedge clk);
    #1 req1 = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    for (int c = 2; c <= 14; c++) b1_v[c-2] = tr_busy1[c];
    chk("u32_busy_c2_c14", b1_v, 13'b0111111111111);
    chk("u32_single_ack", ack_cnt1 - sav, 1);
    chk("u32_no_write_ctl", rd_wr1, 1'b0);
    if (q1.size() != 0) begin
      tests++; fails++;
      $display("FAIL u32_timeout: no ack, %0d pending", q1.size());
      q1.delete();
    end

    // ---- reset during byte-0 strobe of a write
    @(negedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0030; be0 = 2'b11; wdata0 = 16'h5A5A;
    sav = ack_cnt0;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("midrst_we_low", ram_we_n0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_we_n", ram_we_n0, 1'b1);
    chk("midrst_ce_dqoe", {ram_ce_n0, ram_dq_oe0}, 2'b10);
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    #2 chk("midrst_no_ack", ack_cnt0 - sav, 0);

    // ---- normal read after the aborted write
    go16(1'b0, 15'h0010, 2'b00, 16'h0, 9, 32'h1234);
    @(negedge clk); #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
